// File: rtl/fir_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_readout_seq
// Purpose  : Owns the RNS FIR register-read port. On start, waits for the
//            filter's done flag, reads samples 0..SIGNAL_COUNT-1 with a fixed
//            read latency and presents each over a valid/ready handshake.
//            When idle, a manual address is forwarded to the FIR read port.
// Revision : 1.0 - initial release
// ============================================================================
module fir_readout_seq #(
   parameter int SIGNAL_COUNT = 10,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 17,
   parameter int READ_LAT     = 1,
   parameter int DONE_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_manual_en,
   input  logic [ADDR_W-1:0] i_manual_addr,
   input  logic              i_fir_done,
   output logic [ADDR_W-1:0] o_fir_addr,
   input  logic [DATA_W-1:0] i_fir_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_out_addr,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_busy,
   output logic              o_complete,
   output logic              o_timeout_err
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_DONE = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_WAIT_LAT  = 3'd3;
   localparam logic [2:0] S_PRESENT   = 3'd4;

   localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(SIGNAL_COUNT - 1);
   localparam logic [15:0]       c_TIMEOUT  = 16'(DONE_TIMEOUT);
   localparam logic [3:0]        c_LAT      = 4'(READ_LAT);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [15:0]       r_wait_cnt;
   logic [3:0]        r_lat_cnt;
   logic [ADDR_W-1:0] r_fir_addr;
   logic              r_out_valid;
   logic [ADDR_W-1:0] r_out_addr;
   logic [DATA_W-1:0] r_out_data;
   logic              r_complete;
   logic              r_timeout_err;

   logic [15:0]       w_wait_inc;
   logic              w_is_last;
   logic              w_busy;
   logic              w_start_ld;
   logic              w_manual_ld;
   logic              w_wait_step;
   logic              w_timeout;
   logic              w_issue;
   logic              w_lat_step;
   logic              w_capture;
   logic              w_accept;

   assign w_wait_inc = r_wait_cnt + 16'd1;
   assign w_is_last  = (r_idx == c_LAST_IDX);

   // State register; reset aborts any scan immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (i_fir_done)                    w_state_nxt = S_ISSUE;
            else if (w_wait_inc == c_TIMEOUT)  w_state_nxt = S_IDLE;
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT_LAT;
         end
         S_WAIT_LAT: begin
            if (r_lat_cnt == 4'd1) w_state_nxt = S_PRESENT;
         end
         S_PRESENT: begin
            if (i_out_ready) w_state_nxt = w_is_last ? S_IDLE : S_ISSUE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Per-state datapath enables and the busy flag
   always_comb begin
      w_busy      = (r_state != S_IDLE);
      w_start_ld  = (r_state == S_IDLE) && i_start;
      w_manual_ld = (r_state == S_IDLE) && !i_start && i_manual_en;
      w_wait_step = (r_state == S_WAIT_DONE) && !i_fir_done;
      w_timeout   = w_wait_step && (w_wait_inc == c_TIMEOUT);
      w_issue     = (r_state == S_ISSUE);
      w_lat_step  = (r_state == S_WAIT_LAT);
      w_capture   = w_lat_step && (r_lat_cnt == 4'd1);
      w_accept    = (r_state == S_PRESENT) && i_out_ready;
   end

   // Datapath: address, counters, captured sample and sticky status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx         <= '0;
         r_wait_cnt    <= '0;
         r_lat_cnt     <= '0;
         r_fir_addr    <= '0;
         r_out_valid   <= 1'b0;
         r_out_addr    <= '0;
         r_out_data    <= '0;
         r_complete    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_start_ld) begin
            r_complete    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
         end else if (w_manual_ld) begin
            r_fir_addr <= i_manual_addr;
         end
         if (w_wait_step) r_wait_cnt <= w_wait_inc;
         if (w_timeout)   r_timeout_err <= 1'b1;
         if (w_issue) begin
            r_fir_addr <= r_idx;
            r_lat_cnt  <= c_LAT;
         end
         if (w_lat_step) r_lat_cnt <= r_lat_cnt - 4'd1;
         if (w_capture) begin
            r_out_data  <= i_fir_data;
            r_out_addr  <= r_idx;
            r_out_valid <= 1'b1;
         end
         if (w_accept) begin
            r_out_valid <= 1'b0;
            if (w_is_last) r_complete <= 1'b1;
            else           r_idx      <= r_idx + ADDR_W'(1);
         end
      end
   end

   assign o_fir_addr    = r_fir_addr;
   assign o_out_valid   = r_out_valid;
   assign o_out_addr    = r_out_addr;
   assign o_out_data    = r_out_data;
   assign o_busy        = w_busy;
   assign o_complete    = r_complete;
   assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_readout_seq
// Purpose  : Self-checking bench for fir_readout_seq. Two instances run the
//            same scan requests: one with a 1-cycle FIR read path, one with a
//            3-cycle registered read path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_readout_seq;

   localparam int N  = 10;
   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        manual_en;
   logic [15:0] manual_addr;
   logic        fir_done;
   logic [15:0] fir_addr    [2];
   logic [16:0] fir_data    [2];
   logic        out_valid   [2];
   logic        out_ready   [2];
   logic [15:0] out_addr    [2];
   logic [16:0] out_data    [2];
   logic        busy        [2];
   logic        complete    [2];
   logic        timeout_err [2];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int rdy_mode = 0;

   // per-DUT scoreboard state
   int          exp_idx   [2];
   int          got       [2];
   int          hs_cyc    [2];
   int          stall_cnt [2];
   bit          have_hs   [2];
   logic        p_valid   [2];
   logic        p_busy    [2];
   logic [15:0] p_faddr   [2];
   logic [15:0] p_oaddr   [2];
   logic [16:0] p_odata   [2];
   logic [15:0] d1, d2;

   always #5 clk = ~clk;

   fir_readout_seq #(.SIGNAL_COUNT(N), .ADDR_W(16), .DATA_W(17), .READ_LAT(1), .DONE_TIMEOUT(TO)) u_dut0 (
      .clk(clk), .reset(reset), .i_start(start), .i_manual_en(manual_en), .i_manual_addr(manual_addr),
      .i_fir_done(fir_done), .o_fir_addr(fir_addr[0]), .i_fir_data(fir_data[0]),
      .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out_addr(out_addr[0]),
      .o_out_data(out_data[0]), .o_busy(busy[0]), .o_complete(complete[0]), .o_timeout_err(timeout_err[0]));

   fir_readout_seq #(.SIGNAL_COUNT(N), .ADDR_W(16), .DATA_W(17), .READ_LAT(3), .DONE_TIMEOUT(TO)) u_dut1 (
      .clk(clk), .reset(reset), .i_start(start), .i_manual_en(manual_en), .i_manual_addr(manual_addr),
      .i_fir_done(fir_done), .o_fir_addr(fir_addr[1]), .i_fir_data(fir_data[1]),
      .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out_addr(out_addr[1]),
      .o_out_data(out_data[1]), .o_busy(busy[1]), .o_complete(complete[1]), .o_timeout_err(timeout_err[1]));

   // FIR register file model: regData = 3*addr + 5
   function automatic logic [16:0] fir_val(input logic [15:0] a);
      logic [31:0] t;
      t = 32'(a) * 32'd3 + 32'd5;
      return t[16:0];
   endfunction

   // DUT0 sees data one edge after the address; DUT1 through two extra registers
   assign fir_data[0] = fir_val(fir_addr[0]);
   always @(posedge clk) begin
      d1 <= fir_addr[1];
      d2 <= d1;
   end
   assign fir_data[1] = fir_val(d2);

   function automatic int rlat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Transaction-level scoreboard for one DUT, called at each falling edge
   task automatic monitor(input int d);
      bit hs;
      if (reset) begin
         p_valid[d] = 1'b0;
         p_busy[d]  = 1'b0;
         p_faddr[d] = fir_addr[d];
         return;
      end
      hs = p_valid[d] && out_ready[d];
      if (busy[d] && !p_busy[d]) begin
         exp_idx[d] = 0; got[d] = 0; have_hs[d] = 0; stall_cnt[d] = 0;
         check_val($sformatf("d%0d start_clears_complete", d), 32'(complete[d]), 0);
      end
      if (hs) begin
         got[d]++;
         hs_cyc[d]  = cyc;
         have_hs[d] = 1;
         check_val($sformatf("d%0d valid_drop", d), 32'(out_valid[d]), 0);
         if (exp_idx[d] == N - 1) begin
            check_val($sformatf("d%0d last_busy", d), 32'(busy[d]), 0);
            check_val($sformatf("d%0d last_complete", d), 32'(complete[d]), 1);
         end
         exp_idx[d]++;
      end else if (p_valid[d]) begin
         check_val($sformatf("d%0d hold_valid", d), 32'(out_valid[d]), 1);
         check_val($sformatf("d%0d hold_addr", d), 32'(out_addr[d]), 32'(p_oaddr[d]));
         check_val($sformatf("d%0d hold_data", d), 32'(out_data[d]), 32'(p_odata[d]));
      end
      if (out_valid[d] && !p_valid[d]) begin
         check_val($sformatf("d%0d sample_addr", d), 32'(out_addr[d]), 32'(exp_idx[d]));
         check_val($sformatf("d%0d sample_data", d), 32'(out_data[d]), 32'(3 * exp_idx[d] + 5));
         if (have_hs[d])
            check_val($sformatf("d%0d sample_gap", d), 32'(cyc - hs_cyc[d]), 32'(rlat(d) + 1));
      end
      if (busy[d] && fir_addr[d] != p_faddr[d])
         check_val($sformatf("d%0d scan_fir_addr", d), 32'(fir_addr[d]), 32'(exp_idx[d]));
      if (p_busy[d] && !busy[d] && !timeout_err[d])
         check_val($sformatf("d%0d scan_count", d), 32'(got[d]), N);
      if (p_busy[d] && !busy[d] && timeout_err[d])
         check_val($sformatf("d%0d timeout_no_samples", d), 32'(got[d]), 0);
      p_valid[d] = out_valid[d];
      p_busy[d]  = busy[d];
      p_faddr[d] = fir_addr[d];
      p_oaddr[d] = out_addr[d];
      p_odata[d] = out_data[d];
   endtask

   // Scoreboard first, then the downstream ready for the coming edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) monitor(d);
         for (int d = 0; d < 2; d++) begin
            case (rdy_mode)
               1: out_ready[d] = 1'($urandom_range(0, 1));
               2: begin
                  if (out_valid[d] && out_addr[d] == 16'd4 && stall_cnt[d] < 7) begin
                     out_ready[d] = 1'b0;
                     stall_cnt[d]++;
                  end else begin
                     out_ready[d] = 1'b1;
                  end
               end
               default: out_ready[d] = 1'b1;
            endcase
         end
      end
   end

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("%s d%0d fir_addr", tag, d), 32'(fir_addr[d]), 0);
         check_val($sformatf("%s d%0d out_valid", tag, d), 32'(out_valid[d]), 0);
         check_val($sformatf("%s d%0d out_addr", tag, d), 32'(out_addr[d]), 0);
         check_val($sformatf("%s d%0d out_data", tag, d), 32'(out_data[d]), 0);
         check_val($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 0);
         check_val($sformatf("%s d%0d complete", tag, d), 32'(complete[d]), 0);
         check_val($sformatf("%s d%0d timeout_err", tag, d), 32'(timeout_err[d]), 0);
      end
   endtask

   // One full scan: fir_done rises dly cycles after start (0 = already high)
   task automatic run_scan(input int dly, input int mode, input bit drop, input bit man,
                           input logic [15:0] maddr);
      int t;
      rdy_mode  = mode;
      fir_done  = (dly == 0);
      manual_en = man;
      start     = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      manual_addr = maddr;
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("d%0d busy_after_start", d), 32'(busy[d]), 1);
         check_val($sformatf("d%0d start_clears_timeout", d), 32'(timeout_err[d]), 0);
      end
      t = 0;
      while ((busy[0] || busy[1]) && t < 3000) begin
         if (t == dly - 1) fir_done = 1'b1;
         if (drop && t == dly + 2) fir_done = 1'b0;
         @(negedge clk);
         t++;
      end
      check_val("scan_within_bound", 32'(t < 3000), 1);
      manual_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("d%0d end_complete", d), 32'(complete[d]), 1);
         check_val($sformatf("d%0d end_timeout_err", d), 32'(timeout_err[d]), 0);
      end
   endtask

   initial begin
      int t;
      reset = 1'b1; start = 1'b0; manual_en = 1'b0; manual_addr = '0; fir_done = 1'b0;
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      #2 reset = 1'b0;

      // manual address pass-through while idle
      @(negedge clk);
      manual_en = 1'b1; manual_addr = 16'd7;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_val($sformatf("d%0d manual_follow", d), 32'(fir_addr[d]), 7);
      manual_en = 1'b0; manual_addr = 16'd9;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_val($sformatf("d%0d manual_hold", d), 32'(fir_addr[d]), 7);

      // baseline scan: done after 20 cycles, ready high; start together with manual_en
      run_scan(20, 0, 1'b0, 1'b1, 16'd3);
      // stall on sample 4 for 7 cycles
      run_scan(20, 2, 1'b0, 1'b0, 16'd0);
      // fir_done already high, dropping mid-scan
      run_scan(0, 0, 1'b1, 1'b1, 16'd3);

      // timeout: fir_done never rises
      fir_done = 1'b0; rdy_mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("d%0d to_busy_before", d), 32'(busy[d]), 1);
         check_val($sformatf("d%0d to_err_before", d), 32'(timeout_err[d]), 0);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_val($sformatf("d%0d to_busy", d), 32'(busy[d]), 0);
         check_val($sformatf("d%0d to_err", d), 32'(timeout_err[d]), 1);
         check_val($sformatf("d%0d to_complete", d), 32'(complete[d]), 0);
         check_val($sformatf("d%0d to_valid", d), 32'(out_valid[d]), 0);
      end
      repeat (3) @(negedge clk);

      // randomized scans
      for (int i = 0; i < 6; i++)
         run_scan(int'($urandom_range(0, 30)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom_range(100, 60000)));

      // asynchronous reset while sample 6 is presented
      fir_done = 1'b1; rdy_mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!(out_valid[0] && out_addr[0] == 16'd6) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check_val("rst_reach_sample6", 32'(out_valid[0] && out_addr[0] == 16'd6), 1);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      run_scan(5, 1, 1'b0, 1'b0, 16'd0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
